// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus bundle: PC register link, branch redirect, decode stall,
// instruction-memory req/ack channel and the IF/ID register outputs.
// The master side is the fetch unit; the slave side is its environment
// (PC register, execute stage, decode stage and instruction memory).
interface inst_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int INST_W = 16
) ();

  // PC register link
  logic [ADDR_W-1:0] instAddr;
  logic              pcEn;
  logic [ADDR_W-1:0] nextInstAddr;

  // Redirect from execute and back-pressure from decode
  logic              branchTaken;
  logic [ADDR_W-1:0] branchTarget;
  logic              stall;

  // Instruction memory read channel
  logic              imemReq;
  logic [ADDR_W-1:0] imemAddr;
  logic              imemAck;
  logic [INST_W-1:0] imemData;

  // IF/ID pipeline register contents
  logic [INST_W-1:0] ifidInst;
  logic [ADDR_W-1:0] ifidPc;
  logic              ifidValid;

  modport master (
    input  instAddr,
    input  branchTaken,
    input  branchTarget,
    input  stall,
    input  imemAck,
    input  imemData,
    output pcEn,
    output nextInstAddr,
    output imemReq,
    output imemAddr,
    output ifidInst,
    output ifidPc,
    output ifidValid
  );

  modport slave (
    output instAddr,
    output branchTaken,
    output branchTarget,
    output stall,
    output imemAck,
    output imemData,
    input  pcEn,
    input  nextInstAddr,
    input  imemReq,
    input  imemAddr,
    input  ifidInst,
    input  ifidPc,
    input  ifidValid
  );

endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage.
// Issues one req/ack read per PC value, advances the PC only when the read
// for the current PC completes (or on a branch redirect), and loads IF/ID.
// A one-entry skid buffer (HOLD) absorbs a completed read that arrives while
// decode is stalled on a live IF/ID entry. A branch that lands while a read
// is still outstanding parks the stage in DROP, where the old request is kept
// on the bus unchanged until memory acknowledges it, and its data is thrown away.
module inst_fetch_unit #(
  parameter int          ADDR_W  = 16,
  parameter int          INST_W  = 16,
  parameter int unsigned PC_STEP = 1
) (
  input  logic               clk,
  input  logic               reset,
  inst_fetch_unit_if.master  fetch_io
);

  localparam logic [ADDR_W-1:0] STEP_C = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // request at the current PC
    ST_HOLD  = 2'd1,  // completed read parked in the skid buffer
    ST_DROP  = 2'd2   // waiting out a request made stale by a branch
  } state_e;

  // State and datapath registers
  state_e              state_q,      state_d;
  logic [ADDR_W-1:0]   drop_addr_q,  drop_addr_d;
  logic [INST_W-1:0]   hold_inst_q,  hold_inst_d;
  logic [ADDR_W-1:0]   hold_pc_q,    hold_pc_d;
  logic [INST_W-1:0]   ifid_inst_q,  ifid_inst_d;
  logic [ADDR_W-1:0]   ifid_pc_q,    ifid_pc_d;
  logic                ifid_valid_q, ifid_valid_d;

  // Combinational outputs
  logic                pc_en_s;
  logic [ADDR_W-1:0]   next_addr_s;
  logic                imem_req_s;
  logic [ADDR_W-1:0]   imem_addr_s;

  // Local copies of the bus inputs for readability
  logic [ADDR_W-1:0]   inst_addr_s;
  logic                branch_s;
  logic [ADDR_W-1:0]   target_s;
  logic                stall_s;
  logic                ack_s;
  logic [INST_W-1:0]   data_s;

  assign inst_addr_s = fetch_io.instAddr;
  assign branch_s    = fetch_io.branchTaken;
  assign target_s    = fetch_io.branchTarget;
  assign stall_s     = fetch_io.stall;
  assign ack_s       = fetch_io.imemAck;
  assign data_s      = fetch_io.imemData;

  // Next-PC select: a redirect wins, otherwise step past the current PC (wraps).
  always_comb begin
    next_addr_s = inst_addr_s + STEP_C;
    if (branch_s) begin
      next_addr_s = target_s;
    end else begin
      next_addr_s = inst_addr_s + STEP_C;
    end
  end

  // Next-state, IF/ID load, skid buffer and memory/PC control.
  always_comb begin
    state_d      = state_q;
    drop_addr_d  = drop_addr_q;
    hold_inst_d  = hold_inst_q;
    hold_pc_d    = hold_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    pc_en_s      = 1'b0;
    imem_req_s   = 1'b0;
    imem_addr_s  = inst_addr_s;

    // Decode consumes IF/ID whenever it is not stalled; a load below overrides.
    if (!stall_s) begin
      ifid_valid_d = 1'b0;
    end else begin
      ifid_valid_d = ifid_valid_q;
    end

    case (state_q)
      ST_FETCH: begin
        imem_req_s  = 1'b1;
        imem_addr_s = inst_addr_s;
        if (branch_s) begin
          // Redirect: flush IF/ID; any data arriving now is for the wrong path.
          pc_en_s      = 1'b1;
          ifid_valid_d = 1'b0;
          if (!ack_s) begin
            // Request still in flight; remember its address so it stays put.
            drop_addr_d = inst_addr_s;
            state_d     = ST_DROP;
          end else begin
            state_d = ST_FETCH;
          end
        end else if (ack_s) begin
          pc_en_s = 1'b1;
          if (stall_s && ifid_valid_q) begin
            // IF/ID is occupied and not draining: park the word.
            hold_inst_d = data_s;
            hold_pc_d   = inst_addr_s;
            state_d     = ST_HOLD;
          end else begin
            ifid_inst_d  = data_s;
            ifid_pc_d    = inst_addr_s;
            ifid_valid_d = 1'b1;
            state_d      = ST_FETCH;
          end
        end else begin
          // Waiting on memory: PC must not move past the open request.
          pc_en_s = 1'b0;
          state_d = ST_FETCH;
        end
      end

      ST_HOLD: begin
        imem_req_s  = 1'b0;
        imem_addr_s = hold_pc_q;
        if (branch_s) begin
          // Redirect discards both IF/ID and the parked word.
          pc_en_s      = 1'b1;
          ifid_valid_d = 1'b0;
          hold_inst_d  = {INST_W{1'b0}};
          hold_pc_d    = {ADDR_W{1'b0}};
          state_d      = ST_FETCH;
        end else if (!stall_s) begin
          // Decode takes the old entry this edge; the parked word replaces it.
          pc_en_s      = 1'b0;
          ifid_inst_d  = hold_inst_q;
          ifid_pc_d    = hold_pc_q;
          ifid_valid_d = 1'b1;
          state_d      = ST_FETCH;
        end else begin
          pc_en_s = 1'b0;
          state_d = ST_HOLD;
        end
      end

      ST_DROP: begin
        imem_req_s  = 1'b1;
        imem_addr_s = drop_addr_q;
        if (branch_s) begin
          pc_en_s      = 1'b1;
          ifid_valid_d = 1'b0;
        end else begin
          pc_en_s = 1'b0;
        end
        // Once the stale read completes the bus is free for the new PC;
        // its data is never looked at.
        if (ack_s) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_DROP;
        end
      end

      default: begin
        // Unreachable encoding: recover to an empty fetch.
        pc_en_s      = 1'b0;
        imem_req_s   = 1'b0;
        ifid_valid_d = 1'b0;
        state_d      = ST_FETCH;
      end
    endcase

    // Nothing reaches the PC or memory while reset is held.
    if (reset) begin
      pc_en_s    = 1'b0;
      imem_req_s = 1'b0;
    end else begin
      pc_en_s    = pc_en_s;
      imem_req_s = imem_req_s;
    end
  end

  // Register update; synchronous reset returns the stage to an empty FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      drop_addr_q  <= {ADDR_W{1'b0}};
      hold_inst_q  <= {INST_W{1'b0}};
      hold_pc_q    <= {ADDR_W{1'b0}};
      ifid_inst_q  <= {INST_W{1'b0}};
      ifid_pc_q    <= {ADDR_W{1'b0}};
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drop_addr_q  <= drop_addr_d;
      hold_inst_q  <= hold_inst_d;
      hold_pc_q    <= hold_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign fetch_io.pcEn         = pc_en_s;
  assign fetch_io.nextInstAddr = next_addr_s;
  assign fetch_io.imemReq      = imem_req_s;
  assign fetch_io.imemAddr     = imem_addr_s;
  assign fetch_io.ifidInst     = ifid_inst_q;
  assign fetch_io.ifidPc       = ifid_pc_q;
  assign fetch_io.ifidValid    = ifid_valid_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: the bench plays PC register, execute, decode
// and instruction memory. Reset-time vector table, directed corner-case
// sequences, then random traffic checked against a queue-based model of
// the instruction stream.
module tb_inst_fetch_unit;

  localparam int AW = 16;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc;
  int            total = 0;
  int            bad   = 0;

  always #5 clk = ~clk;

  inst_fetch_unit_if #(.ADDR_W(AW), .INST_W(IW)) bus ();

  inst_fetch_unit #(.ADDR_W(AW), .INST_W(IW), .PC_STEP(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .fetch_io (bus)
  );

  assign bus.instAddr = pc;

  typedef struct {
    logic [AW-1:0] addr;
    logic          bt;
    logic [AW-1:0] tgt;
    logic [AW-1:0] exp_next;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } ent_t;

  // Memory contents: fixed function of the address, one word pinned for test 3.
  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 16'h0007) begin
      return 16'hABCD;
    end else begin
      return (a * 16'd3) ^ 16'h5A5A;
    end
  endfunction

  task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Close the current cycle: the PC register loads on the edge if enabled.
  task automatic tick();
    logic          pen;
    logic [AW-1:0] nxt;
    pen = bus.pcEn;
    nxt = bus.nextInstAddr;
    @(posedge clk);
    #1;
    if (pen === 1'b1) pc = nxt;
  endtask

  // One full cycle: edge, drive this cycle's inputs, memory answers, settle to negedge.
  task automatic step(input logic rst, input logic bt, input logic [AW-1:0] tgt,
                      input logic st, input logic ackw);
    tick();
    reset            = rst;
    bus.branchTaken  = bt;
    bus.branchTarget = tgt;
    bus.stall        = st;
    #1;
    bus.imemAck  = ackw & bus.imemReq;
    bus.imemData = bus.imemAck ? mem_word(bus.imemAddr) : 16'hDEAD;
    @(negedge clk);
  endtask

  vec_t          vt [6];
  ent_t          q [$];
  logic          taint;
  logic          outstanding;
  logic [AW-1:0] out_addr;
  logic [AW-1:0] cur_addr;
  logic          exp_req;
  logic          exp_pen;
  logic          ackd;
  logic          live;
  logic          r_rst, r_bt, r_st, r_ack;
  logic [AW-1:0] r_tgt;

  initial begin
    reset            = 1'b1;
    pc               = 16'h0000;
    bus.branchTaken  = 1'b0;
    bus.branchTarget = 16'h0000;
    bus.stall        = 1'b0;
    bus.imemAck      = 1'b0;
    bus.imemData     = 16'h0000;

    vt[0] = '{16'h0000, 1'b0, 16'h0000, 16'h0001};
    vt[1] = '{16'h1234, 1'b0, 16'h9999, 16'h1235};
    vt[2] = '{16'hFFFF, 1'b0, 16'h0000, 16'h0000};
    vt[3] = '{16'h0005, 1'b1, 16'h0040, 16'h0040};
    vt[4] = '{16'hFFFE, 1'b1, 16'hFFFF, 16'hFFFF};
    vt[5] = '{16'h7FFF, 1'b0, 16'h0000, 16'h8000};

    // Reset held: next-PC arithmetic, and no PC/memory activity, empty IF/ID.
    for (int i = 0; i < 6; i++) begin
      pc = vt[i].addr;
      step(1'b1, vt[i].bt, vt[i].tgt, 1'b0, 1'b1);
      chk16("rst_next", bus.nextInstAddr, vt[i].exp_next);
      chk1("rst_pcen", bus.pcEn, 1'b0);
      chk1("rst_req", bus.imemReq, 1'b0);
      chk1("rst_valid", bus.ifidValid, 1'b0);
      chk16("rst_ifidpc", bus.ifidPc, 16'h0000);
      chk16("rst_ifidinst", bus.ifidInst, 16'h0000);
    end

    // 1: zero-wait memory from PC 0, one instruction per cycle.
    pc = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      chk16("t1_addr", bus.imemAddr, 16'(i));
      chk1("t1_pcen", bus.pcEn, 1'b1);
      chk1("t1_valid", bus.ifidValid, i > 0);
      if (i > 0) begin
        chk16("t1_ifidpc", bus.ifidPc, 16'(i - 1));
        chk16("t1_ifidinst", bus.ifidInst, mem_word(16'(i - 1)));
      end
    end

    // 2: two wait cycles at PC 5, then ack.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      chk1("t2_req", bus.imemReq, 1'b1);
      chk16("t2_addr_wait", bus.imemAddr, 16'h0005);
      chk1("t2_pcen_wait", bus.pcEn, 1'b0);
    end
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk16("t2_addr_ack", bus.imemAddr, 16'h0005);
    chk1("t2_pcen_ack", bus.pcEn, 1'b1);
    chk16("t2_next", bus.nextInstAddr, 16'h0006);

    // 3: stalled live IF/ID, ack at PC 7 goes to the skid buffer.
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk1("t3_valid_pre", bus.ifidValid, 1'b1);
    chk16("t3_pc_pre", bus.ifidPc, 16'h0005);
    pc = 16'h0007;
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    chk16("t3_addr", bus.imemAddr, 16'h0007);
    chk1("t3_pcen", bus.pcEn, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    chk1("t3_hold_req", bus.imemReq, 1'b0);
    chk1("t3_hold_pcen", bus.pcEn, 1'b0);
    chk16("t3_hold_ifidpc", bus.ifidPc, 16'h0005);
    chk1("t3_hold_valid", bus.ifidValid, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk1("t3_unstall_req", bus.imemReq, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk16("t3_ifidpc", bus.ifidPc, 16'h0007);
    chk16("t3_ifidinst", bus.ifidInst, 16'hABCD);
    chk1("t3_valid", bus.ifidValid, 1'b1);
    chk16("t3_next_addr", bus.imemAddr, 16'h0008);

    // 4: branch to 0x0040 at PC 10 before ack.
    pc = 16'h000A;
    step(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0);
    chk1("t4_pcen", bus.pcEn, 1'b1);
    chk16("t4_next", bus.nextInstAddr, 16'h0040);
    chk16("t4_addr", bus.imemAddr, 16'h000A);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk16("t4_drop_addr", bus.imemAddr, 16'h000A);
    chk1("t4_drop_req", bus.imemReq, 1'b1);
    chk1("t4_drop_pcen", bus.pcEn, 1'b0);
    chk1("t4_drop_valid", bus.ifidValid, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk16("t4_ack_addr", bus.imemAddr, 16'h000A);
    chk1("t4_ack_pcen", bus.pcEn, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk16("t4_new_addr", bus.imemAddr, 16'h0040);
    chk1("t4_valid_after", bus.ifidValid, 1'b0);

    // 5: branch to 0x0020 while parked in HOLD with stall held.
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    chk16("t5_ifidpc", bus.ifidPc, 16'h0040);
    chk1("t5_pcen", bus.pcEn, 1'b1);
    step(1'b0, 1'b1, 16'h0020, 1'b1, 1'b0);
    chk1("t5_hold_req", bus.imemReq, 1'b0);
    chk1("t5_br_pcen", bus.pcEn, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk16("t5_addr", bus.imemAddr, 16'h0020);
    chk1("t5_valid", bus.ifidValid, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk1("t5_valid_later", bus.ifidValid, 1'b0);

    // 6: PC wrap, then reset while in DROP.
    pc = 16'hFFFF;
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk16("t6_wrap", bus.nextInstAddr, 16'h0000);
    chk1("t6_wrap_pcen", bus.pcEn, 1'b1);
    step(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    chk16("t6_ifidpc", bus.ifidPc, 16'hFFFF);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk16("t6_drop_addr", bus.imemAddr, 16'h0000);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk1("t6_rst_req", bus.imemReq, 1'b0);
    chk1("t6_rst_pcen", bus.pcEn, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk1("t6_rst_valid", bus.ifidValid, 1'b0);
    chk16("t6_rst_ifidpc", bus.ifidPc, 16'h0000);
    chk1("t6_rst_req2", bus.imemReq, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    chk1("t6_post_req", bus.imemReq, 1'b1);
    chk16("t6_post_addr", bus.imemAddr, 16'h0100);

    // Random traffic against a stream model: q holds fetched, not yet consumed
    // instructions (IF/ID first, then the skid entry).
    step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    q.delete();
    taint       = 1'b0;
    outstanding = 1'b0;
    out_addr    = 16'h0000;
    for (int n = 0; n < 3000; n++) begin
      r_rst = ($urandom_range(0, 63) == 0);
      r_bt  = ($urandom_range(0, 99) < 12);
      r_tgt = 16'($urandom);
      r_st  = ($urandom_range(0, 99) < 40);
      r_ack = ($urandom_range(0, 1) == 1);
      step(r_rst, r_bt, r_tgt, r_st, r_ack);

      exp_req  = !r_rst && (q.size() < 2);
      cur_addr = outstanding ? out_addr : pc;
      ackd     = bus.imemAck;
      exp_pen  = !r_rst && (r_bt || (exp_req && ackd && !taint));
      chk1("rnd_req", bus.imemReq, exp_req);
      if (exp_req) chk16("rnd_addr", bus.imemAddr, cur_addr);
      chk1("rnd_pcen", bus.pcEn, exp_pen);
      chk16("rnd_next", bus.nextInstAddr, r_bt ? r_tgt : 16'(pc + 16'd1));
      chk1("rnd_valid", bus.ifidValid, q.size() > 0);
      if (q.size() > 0) begin
        chk16("rnd_ifidpc", bus.ifidPc, q[0].pc);
        chk16("rnd_ifidinst", bus.ifidInst, q[0].inst);
      end

      if (r_rst) begin
        q.delete();
        taint       = 1'b0;
        outstanding = 1'b0;
      end else begin
        if (r_bt) begin
          q.delete();
          if (exp_req && !ackd) taint = 1'b1;
          else if (ackd) taint = 1'b0;
        end else begin
          live = exp_req && ackd && !taint;
          if (ackd) taint = 1'b0;
          if (q.size() > 0 && !r_st) void'(q.pop_front());
          if (live) q.push_back('{cur_addr, mem_word(cur_addr)});
        end
        outstanding = exp_req && !ackd;
        out_addr    = cur_addr;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
